// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: sequential prefetch into a small queue with redirect/flush.
// Optional stall counter port fetch_stall_cnt when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       pc_d    [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       instr_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     head_ptr_q, head_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     inflight_q, inflight_d;

  logic pop_c;
  logic req_fire_c;

  assign out_valid    = filled_q[head_ptr_q];
  assign out_pc       = pc_q[head_ptr_q];
  assign out_instr    = instr_q[head_ptr_q];
  assign pop_c        = out_valid && out_ready;
  assign mem_req_addr = fetch_pc_q;

  // Slots held by the queue plus stale responses still owed bound the issue window.
  assign mem_req_valid = (state_q != BOOT) &&
                         ((SW'(count_q) - SW'(pop_c) + SW'(drop_cnt_q)) < SW'(DEPTH));
  assign req_fire_c    = mem_req_valid && mem_req_ready;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q + CW'(req_fire_c) - CW'(pop_c);
    drop_cnt_d  = drop_cnt_q;
    inflight_d  = inflight_q + CW'(req_fire_c) - CW'(mem_rsp_valid);

    case (state_q)
      BOOT:      state_d = RUN;
      RUN, HOLD: state_d = mem_req_valid ? RUN : HOLD;
      default:   state_d = BOOT;
    endcase

    if (req_fire_c) begin
      pc_d[alloc_ptr_q]     = fetch_pc_q;
      filled_d[alloc_ptr_q] = 1'b0;
      alloc_ptr_d           = alloc_ptr_q + PW'(1);
      fetch_pc_d            = fetch_pc_q + 32'd4;
    end

    if (mem_rsp_valid) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        instr_d[fill_ptr_q]  = mem_rsp_data;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
    end

    if (pop_c) begin
      filled_d[head_ptr_q] = 1'b0;
      head_ptr_d           = head_ptr_q + PW'(1);
    end

    // Flush: everything still outstanding after this cycle comes back stale.
    if (redirect_valid) begin
      fetch_pc_d  = redirect_pc & ~32'h3;
      filled_d    = '0;
      count_d     = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      drop_cnt_d  = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      inflight_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      inflight_q  <= inflight_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Core wanted an instruction but none was ready.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_ready && !out_valid) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a variable-latency in-order memory model.
module tb_fetch_prefetch_unit;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;
  logic [31:0] stall_m = 0;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          got_cyc[$];

  fetch_prefetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Called at a negedge: record handshakes, cross the edge, update the memory model.
  task automatic step();
    logic        fire, rsp;
    logic [31:0] faddr;
    mreq_t       e;
    fire  = mem_req_valid && mem_req_ready;
    faddr = mem_req_addr;
    rsp   = mem_rsp_valid;
    if (out_valid && out_ready) begin
      got_pc.push_back(out_pc);
      got_instr.push_back(out_instr);
      got_cyc.push_back(cyc);
    end
    if (out_ready && !out_valid) stall_m = stall_m + 32'd1;
    @(posedge clk);
    #1;
    if (rsp && mq.size() > 0) void'(mq.pop_front());
    if (fire) begin
      e.addr = faddr;
      e.due  = cyc + lat;
      mq.push_back(e);
      req_log.push_back(faddr);
    end
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = instr_of(mq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      step();
    end
  endtask

  // Asserts reset (possibly mid-operation), checks reset values, releases it.
  task automatic do_reset();
    rst = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    mq.delete(); req_log.delete(); got_pc.delete(); got_instr.delete(); got_cyc.delete();
    stall_m = 0; cyc = 0;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL rst_req_addr got=%h exp=00000100", mem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_out_instr got=%h exp=0", out_instr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", fetch_stall_cnt); end
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    lat = 1; out_ready = 1'b1; mem_req_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_no_req got=%b exp=0", mem_req_valid); end
    step();
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got=%b exp=1", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h100) begin errors++; $display("FAIL first_req_addr got=%h exp=00000100", mem_req_addr); end
    step();
  endtask

  task automatic test_sequential();
    cycles(10);
    checks++; if (got_pc.size() < 6) begin errors++; $display("FAIL seq_count got=%0d exp>=6", got_pc.size()); end
    else begin
      checks++; if (got_cyc[0] !== 3) begin errors++; $display("FAIL seq_first_cycle got=%0d exp=3", got_cyc[0]); end
      for (int i = 0; i < 6; i++) begin
        checks++; if (got_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, got_pc[i], 32'h100 + 32'(4 * i)); end
        checks++; if (got_instr[i] !== instr_of(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL seq_instr[%0d] got=%h", i, got_instr[i]); end
        checks++; if (got_cyc[i] !== got_cyc[0] + i) begin errors++; $display("FAIL seq_back_to_back[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] exp_addr;
    int n_got;
    exp_addr = 32'h100 + 32'(4 * req_log.size());
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (mem_req_addr !== exp_addr || mem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_addr[%0d] got=%h/%b exp=%h/1", i, mem_req_addr, mem_req_valid, exp_addr); end
      if (i == 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b exp=0", out_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (fetch_stall_cnt !== stall_m) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", fetch_stall_cnt, stall_m); end
`endif
      end
      step();
    end
    n_got = got_pc.size();
    mem_req_ready = 1'b1;
    cycles(6);
    checks++; if (got_pc.size() <= n_got) begin errors++; $display("FAIL stall_resume got=%0d exp>%0d", got_pc.size(), n_got); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, got_pc[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_reset();
    cycles(8);
    checks++; if (req_log.size() !== 2) begin errors++; $display("FAIL bp_req_count got=%0d exp=2", req_log.size()); end
    else begin
      checks++; if (req_log[0] !== 32'h100 || req_log[1] !== 32'h104) begin errors++; $display("FAIL bp_req_addrs got=%h,%h exp=100,104", req_log[0], req_log[1]); end
    end
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_blocked got=%b exp=0", mem_req_valid); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/00000100", out_valid, out_pc); end
    checks++; if (out_instr !== instr_of(32'h100)) begin errors++; $display("FAIL bp_head_instr got=%h exp=%h", out_instr, instr_of(32'h100)); end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h108) begin errors++; $display("FAIL bp_resume got=%b/%h exp=1/00000108", mem_req_valid, mem_req_addr); end
    step();
    cycles(6);
    checks++; if (got_pc.size() < 4) begin errors++; $display("FAIL bp_drain_count got=%0d exp>=4", got_pc.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_pc[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_drop();
    int n;
    lat = 3; out_ready = 1'b1;
    do_reset();
    cycles(3);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_full got=%b exp=0", mem_req_valid); end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req_addr !== 32'h200) begin errors++; $display("FAIL rd_addr got=%h exp=00000200", mem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_flushed got=%b exp=0", out_valid); end
    step();
    n = 0;
    while (got_pc.size() == 0 && n < 20) begin
      @(negedge clk);
      step();
      n++;
    end
    checks++; if (got_pc.size() == 0) begin errors++; $display("FAIL rd_timeout got=0 deliveries exp=1"); end
    else begin
      checks++; if (got_pc[0] !== 32'h200) begin errors++; $display("FAIL rd_first_pc got=%h exp=00000200", got_pc[0]); end
      checks++; if (got_instr[0] !== instr_of(32'h200)) begin errors++; $display("FAIL rd_first_instr got=%h exp=%h", got_instr[0], instr_of(32'h200)); end
      checks++; if (got_cyc[0] !== 9) begin errors++; $display("FAIL rd_first_cycle got=%0d exp=9", got_cyc[0]); end
    end
  endtask

  task automatic test_redirect_collision();
    int n;
    lat = 1; out_ready = 1'b1;
    do_reset();
    cycles(7);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h110) begin errors++; $display("FAIL col_head got=%b/%h exp=1/00000110", out_valid, out_pc); end
    step();
    redirect_valid = 1'b0;
    checks++; if (got_pc.size() !== 5 || got_pc[got_pc.size()-1] !== 32'h110) begin errors++; $display("FAIL col_popped got=%0d entries exp=5 ending 110", got_pc.size()); end
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h400) begin errors++; $display("FAIL col_next_req got=%b/%h exp=1/00000400", mem_req_valid, mem_req_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL col_flushed got=%b exp=0", out_valid); end
    step();
    n = 0;
    while (got_pc.size() < 6 && n < 20) begin
      @(negedge clk);
      step();
      n++;
    end
    checks++; if (got_pc.size() < 6) begin errors++; $display("FAIL col_timeout got=%0d deliveries exp=6", got_pc.size()); end
    else begin
      checks++; if (got_pc[5] !== 32'h400) begin errors++; $display("FAIL col_new_pc got=%h exp=00000400", got_pc[5]); end
      checks++; if (got_cyc[5] !== 10) begin errors++; $display("FAIL col_new_cycle got=%0d exp=10", got_cyc[5]); end
    end
  endtask

  task automatic test_wrap();
    lat = 1; out_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", mem_req_valid, mem_req_addr); end
    step();
    @(negedge clk);
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got=%h exp=00000000", mem_req_addr); end
    step();
    cycles(4);
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL wrap_count got=%0d exp>=2", got_pc.size()); end
    else begin
      checks++; if (got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0) begin errors++; $display("FAIL wrap_pcs got=%h,%h exp=fffffffc,00000000", got_pc[0], got_pc[1]); end
    end
  endtask

  initial begin
    rst = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    #2;
    test_reset();
    test_sequential();
    test_mem_stall();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
